// File: rtl/ntt_sched_pkg.sv
// rtl/ntt_sched_pkg.sv - shared types and width helpers for the NTT job scheduler
// Contents: scheduler state enum, default parameter values, and width functions
//   for the bank index (clog2(NREQ)) and the watchdog/reset counters.
package ntt_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERST,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int LOGN_DEF = 12;

  // Bank index width, clog2(NREQ).
  function automatic int idx_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Counter width able to hold 0..n-1; covers the watchdog (clog2(TIMEOUT))
  // and the engine reset counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ntt_job_scheduler_if.sv
// rtl/ntt_job_scheduler_if.sv - scheduler-to-NTT-engine control interface
// Signals: eng_rst (active-high engine reset), eng_start (start level),
//   eng_intt (direction), eng_q (modulus), eng_bank (memory mux select),
//   eng_finish (engine finish level, held until eng_rst).
// Modports: master = scheduler side, slave = engine side.
interface ntt_job_scheduler_if #(
  parameter int LOGQ  = 64,
  parameter int IDX_W = 2
);
  logic             eng_rst;
  logic             eng_start;
  logic             eng_intt;
  logic [LOGQ-1:0]  eng_q;
  logic [IDX_W-1:0] eng_bank;
  logic             eng_finish;

  modport master (
    output eng_rst, eng_start, eng_intt, eng_q, eng_bank,
    input  eng_finish
  );

  modport slave (
    input  eng_rst, eng_start, eng_intt, eng_q, eng_bank,
    output eng_finish
  );
endinterface

// File: rtl/ntt_job_scheduler_rr_arbiter.sv
// rtl/ntt_job_scheduler_rr_arbiter.sv - combinational round-robin arbiter
// Ports: req (request vector), ptr (highest-priority index) in;
//   win (one-hot winner, zero if no request), win_idx (winner index) out.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic [IDX_W-1:0] win_idx
);

  int               j;
  logic [IDX_W-1:0] idx;

  // Walk from the lowest-priority offset up to ptr itself so that the
  // last hit, which overwrites earlier ones, is the first at/after ptr.
  always_comb begin
    win     = '0;
    win_idx = '0;
    j       = 0;
    idx     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      idx = IDX_W'(j);
      if (req[idx]) begin
        win      = '0;
        win[idx] = 1'b1;
        win_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/ntt_job_scheduler.sv
// rtl/ntt_job_scheduler.sv - round-robin job controller sharing one NTT engine
// Ports: clk, rst_n (async active-low); req/req_intt/req_q per requester in;
//   grant (one-hot for the whole job), done/err (one-cycle pulses), busy out;
//   eng (master modport): engine reset, start, direction, modulus, bank select,
//   and the engine finish input. All outputs are registered.
module ntt_job_scheduler
  import ntt_sched_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int LOGQ       = 64,
  parameter int LOGN       = LOGN_DEF,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 2 ** (LOGN + 3)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_intt,
  input  logic [NREQ*LOGQ-1:0] req_q,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic                 busy,
  ntt_job_scheduler_if.master  eng
);

  localparam int BW = idx_w(NREQ);
  localparam int WW = cnt_w(TIMEOUT);
  localparam int RW = cnt_w(RST_CYCLES);

  state_t          state, state_n;
  logic [NREQ-1:0] grant_r, done_r, err_r, win;
  logic            busy_r, rst_r, start_r, intt_r;
  logic [LOGQ-1:0] q_r;
  logic [BW-1:0]   bank_r, ptr, win_idx;
  logic [RW-1:0]   rcnt;
  logic [WW-1:0]   wcnt;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(BW)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  // Finish is checked before the watchdog so a finish arriving on the last
  // allowed RUN cycle still counts as a successful job.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (|req) state_n = S_ERST;
      S_ERST: if (rcnt == RW'(RST_CYCLES - 1)) state_n = S_RUN;
      S_RUN: begin
        if (eng.eng_finish)                 state_n = S_DONE;
        else if (wcnt == WW'(TIMEOUT - 1))  state_n = S_ERR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output registers are loaded from state_n so each output changes on the
  // same edge as the state it belongs to, with no input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      grant_r <= '0;
      done_r  <= '0;
      err_r   <= '0;
      busy_r  <= 1'b0;
      rst_r   <= 1'b1;
      start_r <= 1'b0;
      intt_r  <= 1'b0;
      q_r     <= '0;
      bank_r  <= '0;
      ptr     <= '0;
      rcnt    <= '0;
      wcnt    <= '0;
    end else begin
      state   <= state_n;
      busy_r  <= (state_n != S_IDLE);
      rst_r   <= (state_n != S_RUN);
      start_r <= (state_n == S_RUN);
      done_r  <= (state_n == S_DONE) ? grant_r : '0;
      err_r   <= (state_n == S_ERR)  ? grant_r : '0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant_r <= win;
            bank_r  <= win_idx;
            intt_r  <= req_intt[win_idx];
            q_r     <= req_q[win_idx*LOGQ +: LOGQ];
            rcnt    <= '0;
          end
        end
        S_ERST: begin
          rcnt <= rcnt + 1'b1;
          wcnt <= '0;
        end
        S_RUN: wcnt <= wcnt + 1'b1;
        default: begin
          grant_r <= '0;
          ptr     <= (bank_r == BW'(NREQ - 1)) ? '0 : bank_r + 1'b1;
        end
      endcase
    end
  end

  assign grant         = grant_r;
  assign done          = done_r;
  assign err           = err_r;
  assign busy          = busy_r;
  assign eng.eng_rst   = rst_r;
  assign eng.eng_start = start_r;
  assign eng.eng_intt  = intt_r;
  assign eng.eng_q     = q_r;
  assign eng.eng_bank  = bank_r;

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// tb/tb_ntt_job_scheduler.sv - self-checking bench for ntt_job_scheduler
// Two instances: dut_m (long watchdog) for normal jobs, dut_w (TIMEOUT=16)
// for watchdog and finish/timeout collision cases.
module tb_ntt_job_scheduler;

  localparam int RSTC = 4;
  localparam int TO_M = 1024;
  localparam int TO_W = 16;

  typedef struct {
    bit         sel;
    logic [3:0] req;
    logic [3:0] intt;
    int         delay;
    bit         mut;
    logic [3:0] exp_grant;
    bit         exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_m = '0, req_w = '0, req_intt = '0;
  logic [255:0] req_q;
  logic        fin_m = 1'b0, fin_w = 1'b0;
  logic [3:0]  grant_m, done_m, err_m, grant_w, done_w, err_w;
  logic        busy_m, busy_w;
  logic [63:0] qv [4];
  vec_t        tbl [11];
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  ntt_job_scheduler_if #(.LOGQ(64), .IDX_W(2)) eif_m ();
  ntt_job_scheduler_if #(.LOGQ(64), .IDX_W(2)) eif_w ();
  assign eif_m.eng_finish = fin_m;
  assign eif_w.eng_finish = fin_w;

  ntt_job_scheduler #(.NREQ(4), .LOGQ(64), .LOGN(12), .RST_CYCLES(RSTC), .TIMEOUT(TO_M)) dut_m (
    .clk(clk), .rst_n(rst_n), .req(req_m), .req_intt(req_intt), .req_q(req_q),
    .grant(grant_m), .done(done_m), .err(err_m), .busy(busy_m), .eng(eif_m.master));

  ntt_job_scheduler #(.NREQ(4), .LOGQ(64), .LOGN(12), .RST_CYCLES(RSTC), .TIMEOUT(TO_W)) dut_w (
    .clk(clk), .rst_n(rst_n), .req(req_w), .req_intt(req_intt), .req_q(req_q),
    .grant(grant_w), .done(done_w), .err(err_w), .busy(busy_w), .eng(eif_w.master));

  function automatic logic [3:0] g_of(bit s);  return s ? grant_w : grant_m; endfunction
  function automatic logic [3:0] d_of(bit s);  return s ? done_w  : done_m;  endfunction
  function automatic logic [3:0] e_of(bit s);  return s ? err_w   : err_m;   endfunction
  function automatic logic       b_of(bit s);  return s ? busy_w  : busy_m;  endfunction
  function automatic logic       rst_of(bit s);   return s ? eif_w.eng_rst   : eif_m.eng_rst;   endfunction
  function automatic logic       start_of(bit s); return s ? eif_w.eng_start : eif_m.eng_start; endfunction
  function automatic logic       intt_of(bit s);  return s ? eif_w.eng_intt  : eif_m.eng_intt;  endfunction
  function automatic logic [63:0] q_of(bit s);    return s ? eif_w.eng_q     : eif_m.eng_q;     endfunction
  function automatic logic [1:0] bank_of(bit s);  return s ? eif_w.eng_bank  : eif_m.eng_bank;  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit s, input logic [3:0] v);
    if (s) req_w = v; else req_m = v;
  endtask

  task automatic set_fin(input bit s, input logic v);
    if (s) fin_w = v; else fin_m = v;
  endtask

  task automatic run_vec(input vec_t v);
    int cnt, rc, idx, exp_lat;
    bit s;
    s = v.sel;
    idx = 0;
    for (int i = 0; i < 4; i++) if (v.exp_grant[i]) idx = i;
    req_intt = v.intt;
    set_req(s, v.req);
    cnt = 0;
    while (g_of(s) == 4'b0 && cnt < 20) begin @(negedge clk); cnt++; end
    chk("grant", {60'b0, g_of(s)}, {60'b0, v.exp_grant});
    chk("bank", {62'b0, bank_of(s)}, 64'(idx));
    chk("intt", {63'b0, intt_of(s)}, {63'b0, v.intt[idx]});
    chk("q", q_of(s), qv[idx]);
    rc = 0;
    while (!start_of(s) && rc < 20) begin
      if (rst_of(s)) rc++;
      @(negedge clk);
    end
    chk("rst_cycles", 64'(rc), 64'(RSTC));
    chk("run_ctl", {62'b0, rst_of(s), start_of(s)}, 64'b01);
    cnt = 0;
    while (d_of(s) == 4'b0 && e_of(s) == 4'b0 && cnt < 200) begin
      if (v.delay != 0 && cnt == v.delay) set_fin(s, 1'b1);
      if (v.mut && cnt == 2) begin
        req_q[63:0] = ~qv[0];
        set_req(s, v.req & ~v.exp_grant);
      end
      @(negedge clk);
      cnt++;
    end
    exp_lat = (v.delay != 0) ? v.delay + 1 : (s ? TO_W : TO_M);
    chk("latency", 64'(cnt), 64'(exp_lat));
    chk("done", {60'b0, d_of(s)}, v.exp_err ? 64'b0 : {60'b0, v.exp_grant});
    chk("err", {60'b0, e_of(s)}, v.exp_err ? {60'b0, v.exp_grant} : 64'b0);
    chk("q_hold", q_of(s), qv[idx]);
    chk("end_ctl", {62'b0, rst_of(s), start_of(s)}, 64'b10);
    set_fin(s, 1'b0);
    set_req(s, v.req & ~v.exp_grant);
    req_q[63:0] = qv[0];
    @(negedge clk);
    chk("post_idle", {51'b0, b_of(s), g_of(s), d_of(s), e_of(s)}, 64'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cnt;
    logic seen;
    qv[0] = 64'h0FFF_FFFF_0000_0001;
    qv[1] = 64'h1234_5678_9ABC_DEF1;
    qv[2] = 64'hFFFF_FFFF_0000_0001;
    qv[3] = 64'h0000_0000_0000_0011;
    for (int i = 0; i < 4; i++) req_q[i*64 +: 64] = qv[i];

    // Round-robin 0..3, re-raise 0 and 2, wrap from ptr 3, parameter
    // stability, then watchdog abort, collision and a skip on dut_w.
    tbl[0]  = '{0, 4'b1111, 4'b0101,  5, 0, 4'b0001, 0};
    tbl[1]  = '{0, 4'b1110, 4'b0101,  6, 0, 4'b0010, 0};
    tbl[2]  = '{0, 4'b1100, 4'b0101,  7, 0, 4'b0100, 0};
    tbl[3]  = '{0, 4'b1000, 4'b0101,  8, 0, 4'b1000, 0};
    tbl[4]  = '{0, 4'b0101, 4'b0110,  4, 0, 4'b0001, 0};
    tbl[5]  = '{0, 4'b0100, 4'b0110,  3, 0, 4'b0100, 0};
    tbl[6]  = '{0, 4'b0001, 4'b0001, 50, 0, 4'b0001, 0};
    tbl[7]  = '{0, 4'b0001, 4'b0000, 10, 1, 4'b0001, 0};
    tbl[8]  = '{1, 4'b0010, 4'b0010,  0, 0, 4'b0010, 1};
    tbl[9]  = '{1, 4'b0001, 4'b0000, 15, 0, 4'b0001, 0};
    tbl[10] = '{1, 4'b0100, 4'b0000, 14, 0, 4'b0100, 0};

    repeat (3) @(negedge clk);
    chk("reset_ctl", {60'b0, busy_m, eif_m.eng_rst, eif_m.eng_start, eif_m.eng_intt}, 64'b0100);
    chk("reset_out", {52'b0, grant_m, done_m, err_m}, 64'b0);
    chk("reset_q", eif_m.eng_q, 64'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 11; k++) run_vec(tbl[k]);

    // Async reset mid-RUN on a job granted from ptr=1.
    req_m = 4'b0100;
    cnt = 0;
    while (grant_m == 4'b0 && cnt < 20) begin @(negedge clk); cnt++; end
    chk("arst_grant", {60'b0, grant_m}, 64'b0100);
    cnt = 0;
    while (!eif_m.eng_start && cnt < 20) begin @(negedge clk); cnt++; end
    repeat (3) @(negedge clk);
    fin_m = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", {62'b0, eif_m.eng_rst, eif_m.eng_start}, 64'b10);
    chk("arst_out", {59'b0, busy_m, grant_m}, 64'b0);
    req_m = 4'b0;
    fin_m = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen = seen | (|done_m) | (|err_m); end
    chk("arst_no_pulse", {63'b0, seen}, 64'b0);
    req_m = 4'b1111;
    rst_n = 1'b1;
    cnt = 0;
    while (grant_m == 4'b0 && cnt < 20) begin @(negedge clk); cnt++; end
    chk("arst_ptr0", {60'b0, grant_m}, 64'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ntt_job_scheduler.md
# ntt_job_scheduler

Round-robin job controller that shares one `ntt_memory_wrapper` engine between `NREQ` requesters. Each job is one forward NTT or one INTT on a requester's polynomial bank. For each job the scheduler:
- arbitrates among pending requests and latches the winner's parameters;
- reset-cycles the engine, which is one-shot and must be reset between jobs;
- holds the engine's start level until it reports finish;
- returns a done or error pulse to the winning requester.

A run-phase watchdog guards against a hung engine. The block sits between the polynomial-bank clients and the NTT engine, and owns engine reset, start, `intt`, `q` and bank select.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8)
- `LOGQ`, 64: modulus / coefficient width
- `LOGN`, 12: log2 of polynomial length; used only for the default timeout
- `RST_CYCLES`, 4: engine reset pulse length in cycles (≥1)
- `TIMEOUT`, 2**(LOGN+3): maximum number of RUN cycles before abort

Ports:
- `clk` in 1: clock
- `rst_n` in 1: asynchronous, active-low reset
- `req` in NREQ: level request per requester
- `req_intt` in NREQ: per-requester transform direction; 1 = INTT
- `req_q` in NREQ*LOGQ: per-requester modulus; slice i is `req_q[i*LOGQ +: LOGQ]`
- `grant` out NREQ: one-hot; high for the whole job
- `done` out NREQ: one-cycle pulse on successful completion
- `err` out NREQ: one-cycle pulse on watchdog abort
- `busy` out 1: high when the state is not IDLE
- `eng_rst` out 1: synchronous, active-high engine reset
- `eng_start` out 1: engine start level
- `eng_intt` out 1: latched direction
- `eng_q` out LOGQ: latched modulus
- `eng_bank` out clog2(NREQ): index of the granted requester; drives the memory mux
- `eng_finish` in 1: engine finish level; stays high until `eng_rst`

## Operation
- States: IDLE, ERST, RUN, DONE, ERR.
- IDLE:
  - `eng_rst` is 1 and `eng_start` is 0.
  - If any `req` is high, the round-robin arbiter picks the first requester at or after pointer `ptr`.
  - Register `grant`, `eng_bank`, `eng_intt` and `eng_q` from that requester, then go to ERST.
- ERST:
  - `eng_rst` is 1 for exactly `RST_CYCLES` cycles, counted by `rcnt`.
  - Then go to RUN.
- RUN:
  - `eng_rst` is 0 and `eng_start` is 1.
  - The watchdog `wcnt` increments every cycle.
  - If `eng_finish` is high, go to DONE.
  - Otherwise, if `wcnt` equals `TIMEOUT-1`, go to ERR.
  - If both conditions hold in the same cycle, finish wins.
- DONE or ERR, one cycle each:
  - `done[g]` or `err[g]` is 1, where g is the granted index.
  - `eng_start` is 0 and `eng_rst` is 1.
  - `ptr` is set to (g+1) mod NREQ.
  - `grant` is cleared on exit; the next state is IDLE.
- Job parameters are latched only at grant time. Later changes to `req_intt`, `req_q` or `req` are ignored until the job ends.
- Dropping `req` mid-job does not abort the job.
- A requester must deassert `req` in the cycle after it sees `done` or `err`. If its `req` is still high in IDLE, that is treated as a new request.
- Requesters with `req` low are never granted.
- `ptr` wraps from NREQ-1 to 0.

## Timing
- Reset values (async on `rst_n` low): state IDLE, `grant` 0, `done` 0, `err` 0, `busy` 0, `eng_rst` 1, `eng_start` 0, `eng_intt` 0, `eng_q` 0, `eng_bank` 0, `ptr` 0, `rcnt` 0, `wcnt` 0.
- Asserting `rst_n` mid-job abandons the job with no `done` or `err` pulse. `eng_rst` rises asynchronously.
- With `req` first sampled high at edge T:
  - `grant` is high from T.
  - `eng_rst` is high through edge T+`RST_CYCLES`.
  - `eng_start` is high from T+`RST_CYCLES`.
- When `eng_finish` is sampled high at edge F, the `done` pulse occupies cycle F..F+1. The earliest next grant is at edge F+2.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `ntt_sched_pkg`:
  - state enum
  - `IDX_W = $clog2(NREQ)`
  - watchdog counter width `$clog2(TIMEOUT)`
- Sub-module `rr_arbiter`: combinational. Inputs are `req` and `ptr`; outputs are a one-hot winner and its index.
- One FSM plus counters in the top level.

## Test plan
- Single job: `req`=0001, `req_intt`=1, q0=0x0FFFFFFF00000001, RST_CYCLES=4; the engine model raises finish 50 cycles after start. Expect:
  - `grant`=0001
  - `eng_rst` high for 4 cycles, then `eng_start` high
  - `eng_intt`=1 and `eng_q`=q0
  - one `done[0]` pulse; `busy` low 2 cycles after finish
- Round-robin: `req`=1111 held, and each requester drops `req` after its `done`. Expect grant order 0,1,2,3. Then re-raise `req[0]` and `req[2]` with `ptr`=0: expect grant 0, then 2.
- Watchdog: TIMEOUT=16 and `eng_finish` never rises. Expect:
  - `err[g]` pulse exactly 16 RUN cycles after `eng_start` rises
  - no `done` pulse
  - `eng_rst` reasserted
- Collision: `eng_finish` rises in the same cycle `wcnt`=TIMEOUT-1. Expect `done` and no `err`.
- Parameter stability: change `req_q[0]` and drop `req[0]` mid-RUN. Expect `eng_q` unchanged and the job still completes with `done[0]`.
- Async reset: pull `rst_n` low mid-RUN. Expect, immediately and asynchronously:
  - `eng_rst`=1 and `eng_start`=0
  - `grant`=0 and `busy`=0
  - no `done` pulse
  - the next job after release is granted from `ptr`=0
